// File: rtl/microcode_sequencer_pkg.sv
// Shared control-word layout, opcode map and sequencer state type for the 8-bit bus CPU.
// Bit positions of ctrl_bit_e are the ctrl output bit indices.
package microcode_sequencer_pkg;

  typedef enum logic [4:0] {
    HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI, SR
  } ctrl_bit_e;

  localparam int CTRL_BITS = 17;

  localparam int OP_NOP = 0;
  localparam int OP_LDA = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_STA = 4;
  localparam int OP_LDI = 5;
  localparam int OP_JMP = 6;
  localparam int OP_JC  = 7;
  localparam int OP_JZ  = 8;
  localparam int OP_OUT = 14;
  localparam int OP_HLT = 15;

  typedef enum logic {ST_RUN, ST_HALTED} seq_state_e;

  function automatic logic [CTRL_BITS-1:0] cw(ctrl_bit_e b);
    logic [CTRL_BITS-1:0] m;
    m    = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  localparam logic [CTRL_BITS-1:0] FETCH_T0 = cw(CO) | cw(MI);
  localparam logic [CTRL_BITS-1:0] FETCH_T1 = cw(RO) | cw(II) | cw(CE);

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bundle between the sequencer and the IR/ALU/datapath: opcode and ALU status in, control word and status out.
interface microcode_sequencer_if
  import microcode_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CTRL_W   = CTRL_BITS
);
  logic [OPCODE_W-1:0] opcode;
  logic                alu_carry;
  logic                alu_zero;
  logic [CTRL_W-1:0]   ctrl;
  logic [STEP_W-1:0]   step;
  logic                halted;
  logic                flag_c;
  logic                flag_z;

  modport master (
    input  opcode, alu_carry, alu_zero,
    output ctrl, step, halted, flag_c, flag_z
  );

  modport slave (
    output opcode, alu_carry, alu_zero,
    input  ctrl, step, halted, flag_c, flag_z
  );
endinterface

// File: rtl/microcode_sequencer_rom.sv
// Combinational microcode: {opcode, step, flags} -> control word including the internal SR bit.
// Unlisted steps read as all-zero words; the step counter wraps past them.
module microcode_sequencer_rom
  import microcode_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CTRL_W   = CTRL_BITS
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [STEP_W-1:0]   i_step,
  input  logic                i_flag_c,
  input  logic                i_flag_z,
  output logic [CTRL_W-1:0]   o_ctrl
);

  logic [31:0]          w_op;
  logic [31:0]          w_st;
  logic [CTRL_BITS-1:0] w_word;

  assign w_op = 32'(i_opcode);
  assign w_st = 32'(i_step);

  always_comb begin
    w_word = '0;
    if (w_st == 0) begin
      w_word = FETCH_T0;
    end else if (w_st == 1) begin
      w_word = FETCH_T1;
    end else begin
      case (w_op)
        OP_LDA: case (w_st)
          2: w_word = cw(IO) | cw(MI);
          3: w_word = cw(RO) | cw(AI);
          4: w_word = cw(SR);
          default: ;
        endcase
        OP_ADD, OP_SUB: case (w_st)
          2: w_word = cw(IO) | cw(MI);
          3: w_word = cw(RO) | cw(BI);
          4: w_word = cw(EO) | cw(AI) | cw(FI) | ((w_op == OP_SUB) ? cw(SU) : '0);
          5: w_word = cw(SR);
          default: ;
        endcase
        OP_STA: case (w_st)
          2: w_word = cw(IO) | cw(MI);
          3: w_word = cw(AO) | cw(RI);
          4: w_word = cw(SR);
          default: ;
        endcase
        OP_LDI: case (w_st)
          2: w_word = cw(IO) | cw(AI);
          3: w_word = cw(SR);
          default: ;
        endcase
        OP_JMP: case (w_st)
          2: w_word = cw(IO) | cw(J);
          3: w_word = cw(SR);
          default: ;
        endcase
        // A not-taken branch is an empty step, keeping every instruction's length fixed.
        OP_JC: case (w_st)
          2: w_word = i_flag_c ? (cw(IO) | cw(J)) : '0;
          3: w_word = cw(SR);
          default: ;
        endcase
        OP_JZ: case (w_st)
          2: w_word = i_flag_z ? (cw(IO) | cw(J)) : '0;
          3: w_word = cw(SR);
          default: ;
        endcase
        OP_OUT: case (w_st)
          2: w_word = cw(AO) | cw(OI);
          3: w_word = cw(SR);
          default: ;
        endcase
        OP_HLT: if (w_st == 2) w_word = cw(HLT);
        OP_NOP: if (w_st == 2) w_word = cw(SR);
        default: if (w_st == 2) w_word = cw(SR);
      endcase
    end
  end

  assign o_ctrl = CTRL_W'(w_word);

endmodule

// File: rtl/microcode_sequencer.sv
// Step counter and halt FSM (negedge), flag register (posedge) and control-word masking around the ROM.
// Stepping on negedge settles ctrl half a cycle before the datapath samples it.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 8,
  parameter int CTRL_W    = CTRL_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  microcode_sequencer_if.master bus
);

  seq_state_e          r_state;
  logic [STEP_W-1:0]   r_step;
  logic                r_flag_c;
  logic                r_flag_z;
  logic [CTRL_W-1:0]   w_rom;
  logic [CTRL_W-1:0]   w_ctrl;

  microcode_sequencer_rom #(
    .OPCODE_W (OPCODE_W),
    .STEP_W   (STEP_W),
    .CTRL_W   (CTRL_W)
  ) u_rom (
    .i_opcode (bus.opcode),
    .i_step   (r_step),
    .i_flag_c (r_flag_c),
    .i_flag_z (r_flag_z),
    .o_ctrl   (w_rom)
  );

  always_comb begin
    w_ctrl = '0;
    if (!rst) begin
      if (r_state == ST_HALTED) w_ctrl[HLT] = 1'b1;
      else                      w_ctrl      = w_rom;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_step  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_rom[HLT])
            r_state <= ST_HALTED;
          else if (w_rom[SR] || (r_step == STEP_W'(MAX_STEPS - 1)))
            r_step  <= '0;
          else
            r_step  <= r_step + 1'b1;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_ctrl[FI]) begin
      r_flag_c <= bus.alu_carry;
      r_flag_z <= bus.alu_zero;
    end
  end

  assign bus.ctrl   = w_ctrl;
  assign bus.step   = r_step;
  assign bus.halted = (r_state == ST_HALTED);
  assign bus.flag_c = r_flag_c;
  assign bus.flag_z = r_flag_z;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against an instruction-list reference model.
module tb_microcode_sequencer;

  localparam int HLT_B = 0,  MI_B = 1,  RI_B = 2,  RO_B = 3,  IO_B = 4,  II_B = 5;
  localparam int AI_B  = 6,  AO_B = 7,  EO_B = 8,  SU_B = 9,  BI_B = 10, OI_B = 11;
  localparam int CE_B  = 12, CO_B = 13, J_B  = 14, FI_B = 15, SR_B = 16;

  typedef logic [16:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  microcode_sequencer_if #(.OPCODE_W(4), .STEP_W(3), .CTRL_W(17)) bus();

  microcode_sequencer #(
    .OPCODE_W(4), .STEP_W(3), .MAX_STEPS(8), .CTRL_W(17)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int m_step   = 0;
  bit m_halted = 1'b0;
  bit m_fc     = 1'b0;
  bit m_fz     = 1'b0;

  function automatic word_t b(int i);
    return word_t'(1) << i;
  endfunction

  // Each instruction is a list of bus words; the step after the last one is T0 again.
  function automatic word_t pword(int op, int idx, bit fc, bit fz);
    word_t q[$];
    q = {b(CO_B) | b(MI_B), b(RO_B) | b(II_B) | b(CE_B)};
    case (op)
      1: begin q.push_back(b(IO_B) | b(MI_B)); q.push_back(b(RO_B) | b(AI_B)); end
      2, 3: begin
        q.push_back(b(IO_B) | b(MI_B));
        q.push_back(b(RO_B) | b(BI_B));
        q.push_back(b(EO_B) | b(AI_B) | b(FI_B) | ((op == 3) ? b(SU_B) : word_t'(0)));
      end
      4:  begin q.push_back(b(IO_B) | b(MI_B)); q.push_back(b(AO_B) | b(RI_B)); end
      5:  q.push_back(b(IO_B) | b(AI_B));
      6:  q.push_back(b(IO_B) | b(J_B));
      7:  q.push_back(fc ? (b(IO_B) | b(J_B)) : word_t'(0));
      8:  q.push_back(fz ? (b(IO_B) | b(J_B)) : word_t'(0));
      14: q.push_back(b(AO_B) | b(OI_B));
      15: q.push_back(b(HLT_B));
      default: ;
    endcase
    if (op != 15) q.push_back(b(SR_B));
    return (idx < q.size()) ? q[idx] : word_t'(0);
  endfunction

  function automatic int plen(int op);
    case (op)
      1, 4:               return 5;
      2, 3:               return 6;
      5, 6, 7, 8, 14:     return 4;
      default:            return 3;
    endcase
  endfunction

  function automatic word_t exp_ctrl();
    if (rst)      return '0;
    if (m_halted) return b(HLT_B);
    return pword(int'(bus.opcode), m_step, m_fc, m_fz);
  endfunction

  // Advance one full clock and the model; returns mid low phase after the negedge.
  task automatic tick();
    word_t w;
    @(posedge clk);
    w = exp_ctrl();
    if (rst) begin
      m_fc = 1'b0; m_fz = 1'b0;
    end else if (w[FI_B]) begin
      m_fc = bus.alu_carry; m_fz = bus.alu_zero;
    end
    @(negedge clk);
    if (rst) begin
      m_step = 0; m_halted = 1'b0;
    end else if (!m_halted) begin
      w = exp_ctrl();
      if (w[HLT_B])                                                m_halted = 1'b1;
      else if ((m_step + 1 >= plen(int'(bus.opcode))) || m_step == 7) m_step = 0;
      else                                                         m_step++;
    end
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.opcode = 4'd2; bus.alu_carry = 1'b1; bus.alu_zero = 1'b1;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.ctrl, bus.step, bus.halted, bus.flag_c, bus.flag_z} !== {17'h0, 3'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: got ctrl=%h step=%0d h=%b c=%b z=%b, want all zero",
               bus.ctrl, bus.step, bus.halted, bus.flag_c, bus.flag_z);
    end
  endtask

  task automatic test_fetch();
    int seq[5];
    seq = '{0, 1, 2, 3, 0};
    bus.opcode = 4'd5;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.ctrl !== exp_ctrl() || int'(bus.step) != seq[i]) begin
        failures++;
        $display("FAIL fetch_ldi t%0d: got ctrl=%h step=%0d, want ctrl=%h step=%0d",
                 i, bus.ctrl, bus.step, exp_ctrl(), seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_add();
    bus.opcode = 4'd2; bus.alu_carry = 1'b1; bus.alu_zero = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.ctrl, bus.step, bus.flag_c, bus.flag_z} !== {exp_ctrl(), 3'(m_step), m_fc, m_fz}) begin
        failures++;
        $display("FAIL add t%0d: got %h, want %h", i,
                 {bus.ctrl, bus.step, bus.flag_c, bus.flag_z}, {exp_ctrl(), 3'(m_step), m_fc, m_fz});
      end
      tick();
    end
    checks++;
    if ({bus.step, bus.flag_c, bus.flag_z} !== {3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_flags: got step=%0d c=%b z=%b, want step=0 c=1 z=0",
               bus.step, bus.flag_c, bus.flag_z);
    end
  endtask

  task automatic test_jumps();
    for (int k = 0; k < 2; k++) begin
      bus.opcode = 4'd3; bus.alu_carry = k[0]; bus.alu_zero = ~k[0];
      do_reset();
      repeat (6) tick();
      for (int op = 7; op <= 8; op++) begin
        bus.opcode = 4'(op);
        bus.alu_carry = ~k[0]; bus.alu_zero = k[0];
        for (int i = 0; i < 4; i++) begin
          checks++;
          if ({bus.ctrl, bus.step, bus.flag_c, bus.flag_z} !== {exp_ctrl(), 3'(m_step), m_fc, m_fz}) begin
            failures++;
            $display("FAIL jump op%0d k%0d t%0d: got %h, want %h", op, k, i,
                     {bus.ctrl, bus.step, bus.flag_c, bus.flag_z}, {exp_ctrl(), 3'(m_step), m_fc, m_fz});
          end
          tick();
        end
        checks++;
        if (bus.step !== 3'd0) begin
          failures++;
          $display("FAIL jump_len op%0d k%0d: got step=%0d, want 0", op, k, bus.step);
        end
      end
    end
  endtask

  task automatic test_halt();
    bus.opcode = 4'd15;
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.ctrl, bus.step, bus.halted} !== {b(HLT_B), 3'd2, 1'b1}) begin
        failures++;
        $display("FAIL halt c%0d: got ctrl=%h step=%0d h=%b, want ctrl=%h step=2 h=1",
                 i, bus.ctrl, bus.step, bus.halted, b(HLT_B));
      end
      bus.opcode = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.ctrl, bus.step, bus.halted} !== {17'h0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL halt_release: got ctrl=%h step=%0d h=%b, want 0/0/0", bus.ctrl, bus.step, bus.halted);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.opcode = 4'd2; bus.alu_carry = 1'b1; bus.alu_zero = 1'b1;
    do_reset();
    repeat (6) tick();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ctrl !== 17'h0 || bus.step !== 3'd3 || bus.flag_c !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ctrl: got ctrl=%h step=%0d c=%b, want ctrl=0 step=3 c=1",
               bus.ctrl, bus.step, bus.flag_c);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.ctrl, bus.step, bus.flag_c, bus.flag_z} !== {b(CO_B) | b(MI_B), 3'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid_after: got ctrl=%h step=%0d c=%b z=%b, want ctrl=%h step=0 c=0 z=0",
               bus.ctrl, bus.step, bus.flag_c, bus.flag_z, b(CO_B) | b(MI_B));
    end
  endtask

  task automatic test_undef();
    int seq[4];
    seq = '{0, 1, 2, 0};
    bus.opcode = 4'd10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.ctrl !== exp_ctrl() || int'(bus.step) != seq[i]) begin
        failures++;
        $display("FAIL undef t%0d: got ctrl=%h step=%0d, want ctrl=%h step=%0d",
                 i, bus.ctrl, bus.step, exp_ctrl(), seq[i]);
      end
      if (i == 2) begin
        checks++;
        if ((bus.ctrl & ~b(SR_B)) !== 17'h0) begin
          failures++;
          $display("FAIL undef_bus: got bus lines %h at T2, want 0", bus.ctrl & ~b(SR_B));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      checks++;
      if ({bus.ctrl, bus.step, bus.halted, bus.flag_c, bus.flag_z} !==
          {exp_ctrl(), 3'(m_step), m_halted, m_fc, m_fz}) begin
        failures++;
        $display("FAIL random c%0d op%0d: got %h, want %h", i, bus.opcode,
                 {bus.ctrl, bus.step, bus.halted, bus.flag_c, bus.flag_z},
                 {exp_ctrl(), 3'(m_step), m_halted, m_fc, m_fz});
      end
      if (m_step == 0 && !m_halted) bus.opcode = 4'($urandom_range(0, 15));
      bus.alu_carry = 1'($urandom_range(0, 1));
      bus.alu_zero  = 1'($urandom_range(0, 1));
      rst = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.opcode = '0; bus.alu_carry = 1'b0; bus.alu_zero = 1'b0;
    #2;
    test_reset();
    test_fetch();
    test_add();
    test_jumps();
    test_halt();
    test_reset_mid();
    test_undef();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
